// File: rtl/fp_addsub_issue_ctrl.sv
// ============================================================================
// Module   : fp_addsub_issue_ctrl
// Brief    : Two-requester issue arbiter for the pipelined FP add/sub unit,
//            with a shadow tag pipeline for result tagging, RAW lookup and
//            selective flush of speculative (requester-0) ops.
//            Optional macro FPAS_SHADOW_CHECK_EN enables the sticky
//            shadow/unit consistency check on err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_issue_ctrl #(
    parameter int LATENCY = 3,
    parameter int RD_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [RD_W-1:0]     req0_rd,
    input  logic                req0_fp_wr,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [RD_W-1:0]     req1_rd,
    input  logic                req1_fp_wr,
    output logic                req1_ready,
    output logic                grant_sel,
    output logic                unit_start,
    output logic                unit_en,
    output logic [LATENCY-1:0]  unit_clear,
    input  logic                unit_result,
    input  logic                wb_stall,
    input  logic                flush,
    output logic                res_valid,
    output logic                res_owner,
    output logic [RD_W-1:0]     res_rd,
    output logic                res_fp_wr,
    input  logic [RD_W-1:0]     hz_rd,
    output logic                hz_hit,
    output logic                busy,
    output logic                err
);

    typedef struct packed {
        logic            v;
        logic            owner;
        logic [RD_W-1:0] rd;
        logic            fp_wr;
    } slot_t;

    slot_t r_s [LATENCY];
    logic  r_flush_pend;
    logic  r_last_grant;

    logic  w_stall;
    logic  w_flush_act;
    logic  w_issue;
    logic  w_winner;
    logic  w_advance;
    slot_t w_new;
    logic  w_hz_hit;
    logic  w_busy;

    assign w_stall     = wb_stall & r_s[LATENCY-1].v;
    assign unit_en     = ~w_stall;
    assign w_flush_act = (flush | r_flush_pend) & ~w_stall;

    // Both valid: the requester not granted last time wins.
    assign w_winner = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_issue  = unit_en & ~w_flush_act & ~r_flush_pend & (req0_valid | req1_valid);

    assign req0_ready = w_issue & ~w_winner;
    assign req1_ready = w_issue &  w_winner;
    assign unit_start = w_issue;
    assign grant_sel  = w_issue ? w_winner : r_last_grant;

    always_comb begin
        w_new       = '0;
        w_new.v     = 1'b1;
        w_new.owner = w_winner;
        w_new.rd    = w_winner ? req1_rd    : req0_rd;
        w_new.fp_wr = w_winner ? req1_fp_wr : req0_fp_wr;
    end

    // Clearing a stage kills the op moving into it; only speculative ops die.
    assign unit_clear[0] = w_flush_act;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_clear
            assign unit_clear[gi] = w_flush_act & r_s[gi-1].v & ~r_s[gi-1].owner;
        end
    endgenerate

    assign w_advance = unit_en | (|unit_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_s[i] <= '0;
            end
            r_flush_pend <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_advance) begin
                r_s[0] <= (w_issue && !unit_clear[0]) ? w_new : '0;
                for (int i = 1; i < LATENCY; i++) begin
                    r_s[i] <= unit_clear[i] ? '0 : r_s[i-1];
                end
            end
            if (w_flush_act) begin
                r_flush_pend <= 1'b0;
            end else if (flush && w_stall) begin
                r_flush_pend <= 1'b1;
            end
            if (w_issue) begin
                r_last_grant <= w_winner;
            end
        end
    end

    always_comb begin
        w_hz_hit = 1'b0;
        w_busy   = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_busy   = w_busy | r_s[i].v;
            w_hz_hit = w_hz_hit | (r_s[i].v & r_s[i].fp_wr & (r_s[i].rd == hz_rd));
        end
    end

    assign hz_hit    = w_hz_hit;
    assign busy      = w_busy;
    assign res_valid = r_s[LATENCY-1].v;
    assign res_owner = r_s[LATENCY-1].owner;
    assign res_rd    = r_s[LATENCY-1].rd;
    assign res_fp_wr = r_s[LATENCY-1].fp_wr;

`ifdef FPAS_SHADOW_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (unit_result != r_s[LATENCY-1].v) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_result;
    assign w_unused_result = unit_result;
    assign err             = 1'b0;
`endif

endmodule

`default_nettype wire
